// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the instruction-cycle sequencer: PC drive codes,
// execute-stage opcodes and FSM state encoding.
package pc_sequencer_pkg;

  localparam logic [2:0] PC_HOLD = 3'b000;
  localparam logic [2:0] PC_INC  = 3'b001;
  localparam logic [2:0] PC_DEC  = 3'b010;
  localparam logic [2:0] PC_SET  = 3'b011;
  localparam logic [2:0] PC_ADD  = 3'b100;

  localparam logic [1:0] OP_NEXT = 2'b00;
  localparam logic [1:0] OP_JABS = 2'b01;
  localparam logic [1:0] OP_JREL = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam logic [2:0] ST_BOOT   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_UPDATE = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  typedef enum logic [2:0] {
    S_BOOT   = ST_BOOT,
    S_FETCH  = ST_FETCH,
    S_DECODE = ST_DECODE,
    S_EXEC   = ST_EXEC,
    S_UPDATE = ST_UPDATE,
    S_HALT   = ST_HALT
  } state_t;

  // PC_DEC is deliberately never produced; it stays reserved for debug access.
  function automatic logic [2:0] drive_for_op(input logic [1:0] op);
    case (op)
      OP_NEXT: return PC_INC;
      OP_JABS: return PC_SET;
      OP_JREL: return PC_ADD;
      default: return PC_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of fetch, execute and PC-control signals around the sequencer.
// master = sequencer side, slave = memory/execute/PC side.
interface pc_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        ir_valid;
  logic        exec_done;
  logic [1:0]  exec_op;
  logic [31:0] exec_target;
  logic [2:0]  pc_drive;
  logic [31:0] pc_set;
  logic        halted;
  logic        fault;
  logic [31:0] instr_count;

  modport master (
    output imem_req, ir, ir_valid, pc_drive, pc_set, halted, fault, instr_count,
    input  imem_ack, imem_rdata, exec_done, exec_op, exec_target
  );

  modport slave (
    input  imem_req, ir, ir_valid, pc_drive, pc_set, halted, fault, instr_count,
    output imem_ack, imem_rdata, exec_done, exec_op, exec_target
  );
endinterface

// File: rtl/pc_sequencer_fetch_watchdog.sv
// Fetch timeout counter: counts unacknowledged FETCH cycles and flags the
// cycle on which the FETCH_TIMEOUT-th consecutive miss occurs.
module fetch_watchdog #(
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [7:0] TC = 8'(FETCH_TIMEOUT - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (i_clear) begin
      r_cnt <= 8'd0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expired = i_enable && (r_cnt == TC);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-cycle controller: fetch -> decode -> execute -> PC update,
// with fetch timeout fault and retired-instruction counter.
//
//   state  | meaning
//   BOOT   | hold RESET_PC_HOLD cycles after reset
//   FETCH  | imem_req high, wait for imem_ack or timeout
//   DECODE | ir_valid pulse, ir freshly latched
//   EXEC   | wait for exec_done, capture op/target
//   UPDATE | one cycle of non-zero pc_drive
//   HALT   | terminal, only rst leaves
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 16,
  parameter int RESET_PC_HOLD = 2
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);

  localparam logic [15:0] BOOT_TC = 16'(RESET_PC_HOLD - 1);

  state_t      r_state;
  logic [15:0] r_boot_cnt;
  logic [31:0] r_ir;
  logic [2:0]  r_pc_drive;
  logic [31:0] r_pc_set;
  logic        r_halted;
  logic        r_fault;
  logic [31:0] r_instr_count;

  logic w_in_fetch;
  logic w_wd_clear;
  logic w_wd_enable;
  logic w_wd_expired;

  assign w_in_fetch  = (r_state == S_FETCH);
  assign w_wd_enable = w_in_fetch && !bus.imem_ack;
  assign w_wd_clear  = !w_in_fetch || bus.imem_ack;

  fetch_watchdog #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_wd_clear),
    .i_enable  (w_wd_enable),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_BOOT;
      r_boot_cnt    <= 16'd0;
      r_ir          <= 32'd0;
      r_pc_drive    <= PC_HOLD;
      r_pc_set      <= 32'd0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
      r_instr_count <= 32'd0;
    end else begin
      case (r_state)
        S_BOOT: begin
          if (r_boot_cnt == BOOT_TC) begin
            r_state <= S_FETCH;
          end else begin
            r_boot_cnt <= r_boot_cnt + 16'd1;
          end
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            r_ir    <= bus.imem_rdata;
            r_state <= S_DECODE;
          end else if (w_wd_expired) begin
            r_fault  <= 1'b1;
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end
        end
        S_DECODE: begin
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (bus.exec_done) begin
            r_instr_count <= r_instr_count + 32'd1;
            if (bus.exec_op == OP_HALT) begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_pc_drive <= drive_for_op(bus.exec_op);
              r_pc_set   <= (bus.exec_op == OP_NEXT) ? 32'd0 : bus.exec_target;
              r_state    <= S_UPDATE;
            end
          end
        end
        S_UPDATE: begin
          r_pc_drive <= PC_HOLD;
          r_state    <= S_FETCH;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_pc_drive <= PC_HOLD;
          r_state    <= S_HALT;
        end
      endcase
    end
  end

  assign bus.imem_req    = w_in_fetch;
  assign bus.ir_valid    = (r_state == S_DECODE);
  assign bus.ir          = r_ir;
  assign bus.pc_drive    = r_pc_drive;
  assign bus.pc_set      = r_pc_set;
  assign bus.halted      = r_halted;
  assign bus.fault       = r_fault;
  assign bus.instr_count = r_instr_count;

endmodule
